// File: rtl/modem_pkg.sv
// Shared modem definitions: write-FSM states, default symbol geometry,
// and I/Q field positions within a packed sample word.
package modem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SKIP_CP,
    FILL,
    DROP
  } wr_state_t;

  localparam int FFT_LEN_DEF = 64;
  localparam int CP_LEN_DEF  = 16;

  localparam int I_MSB = 31;
  localparam int I_LSB = 16;
  localparam int Q_MSB = 15;
  localparam int Q_LSB = 0;

endpackage

// File: rtl/cp_strip_fft_buffer_if.sv
// Sample-stream bundle between the DFE, the CP stripper and the FFT.
// master drives samples in and takes words out; slave is the buffer.
interface cp_strip_fft_buffer_if #(
  parameter int DW = 32
);
  logic          enable;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          sym_start;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overflow;
  logic          sync_err;

  modport master (
    output enable, in_data, in_valid,
    output sym_start, out_ready,
    input  out_data, out_valid, out_last,
    input  overflow, sync_err
  );

  modport slave (
    input  enable, in_data, in_valid,
    input  sym_start, out_ready,
    output out_data, out_valid, out_last,
    output overflow, sync_err
  );
endinterface

// File: rtl/sample_bank_ram.sv
// Two-bank sample store: one write port, one registered read port
// whose output holds while re is low.
module sample_bank_ram #(
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cp_strip_fft_buffer.sv
// Strips the cyclic prefix and ping-pongs FFT_LEN useful samples
// per symbol into two banks, streamed out to the FFT.
module cp_strip_fft_buffer
  import modem_pkg::*;
#(
  parameter int FFT_LEN = FFT_LEN_DEF,
  parameter int CP_LEN  = CP_LEN_DEF,
  parameter int DW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  cp_strip_fft_buffer_if.slave bus
);
  localparam int IW = $clog2(FFT_LEN);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST = CW'(FFT_LEN - 1);
  localparam logic [CW-1:0] CPL  = CW'(CP_LEN);

  wr_state_t     st;
  logic [CW-1:0] cnt;
  logic          wb, rb, ib;
  logic [1:0]    full;
  logic [CW-1:0] ri;
  logic          v1, l1;
  logic [DW-1:0] rdata;
  logic [DW-1:0] out_data_r;
  logic          out_valid_r, out_last_r;
  logic          overflow_r, sync_err_r;

  logic          iv, ss, flush;
  logic          xfer, rel, adv, ren, free;
  logic          we, wdone;
  logic [IW-1:0] widx;
  logic [1:0]    set_m, clr_m;

  assign iv    = bus.in_valid;
  assign ss    = bus.in_valid & bus.sym_start;
  assign flush = ~bus.enable;
  assign xfer  = out_valid_r & bus.out_ready;
  assign rel   = xfer & out_last_r;
  // a bank drained on this very edge may be refilled at once
  assign free  = ~full[wb] | (rel & (rb == wb));
  assign adv   = ~out_valid_r | bus.out_ready;
  assign ren   = adv & full[ib];
  assign set_m = wdone ? (2'b01 << wb) : 2'b00;
  assign clr_m = rel ? (2'b01 << rb) : 2'b00;

  always_comb begin
    we    = 1'b0;
    wdone = 1'b0;
    widx  = '0;
    if (iv && !ss) begin
      if (st == SKIP_CP && cnt == CPL && free) begin
        we = 1'b1;
      end
      if (st == FILL) begin
        we    = 1'b1;
        widx  = cnt[IW-1:0];
        wdone = (cnt == LAST);
      end
    end
  end

  sample_bank_ram #(
    .DW (DW),
    .AW (IW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wb, widx}),
    .wdata (bus.in_data),
    .re    (ren),
    .raddr ({ib, ri[IW-1:0]}),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      wb         <= 1'b0;
      overflow_r <= 1'b0;
      sync_err_r <= 1'b0;
    end else if (flush) begin
      st         <= IDLE;
      cnt        <= '0;
      wb         <= 1'b0;
      overflow_r <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      overflow_r <= 1'b0;
      sync_err_r <= 1'b0;
      unique case (st)
        IDLE: begin
          if (ss) begin
            st  <= SKIP_CP;
            cnt <= CW'(1);
          end
        end
        SKIP_CP: begin
          if (ss && cnt != '0) begin
            sync_err_r <= 1'b1;
            cnt        <= CW'(1);
          end else if (iv && cnt != CPL) begin
            cnt <= cnt + 1'b1;
          end else if (iv) begin
            cnt <= CW'(1);
            if (free) begin
              st <= FILL;
            end else begin
              st         <= DROP;
              overflow_r <= 1'b1;
            end
          end
        end
        FILL, DROP: begin
          if (ss) begin
            sync_err_r <= 1'b1;
            st         <= SKIP_CP;
            cnt        <= CW'(1);
          end else if (iv && cnt == LAST) begin
            st  <= SKIP_CP;
            cnt <= '0;
            if (st == FILL) wb <= ~wb;
          end else if (iv) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // two-stage read: RAM register, then output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full        <= '0;
      rb          <= 1'b0;
      ib          <= 1'b0;
      ri          <= '0;
      v1          <= 1'b0;
      l1          <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else if (flush) begin
      full        <= '0;
      rb          <= 1'b0;
      ib          <= 1'b0;
      ri          <= '0;
      v1          <= 1'b0;
      l1          <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else begin
      full <= (full & ~clr_m) | set_m;
      if (rel) rb <= ~rb;
      if (adv) begin
        v1          <= ren;
        l1          <= ren & (ri == LAST);
        out_valid_r <= v1;
        out_last_r  <= v1 & l1;
        out_data_r  <= v1 ? rdata : '0;
      end
      if (ren) begin
        if (ri == LAST) begin
          ri <= '0;
          ib <= ~ib;
        end else begin
          ri <= ri + 1'b1;
        end
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign bus.overflow  = overflow_r;
  assign bus.sync_err  = sync_err_r;
endmodule
